// File: rtl/rom_port_sched_if.sv
// Bus bundle between rom_port_sched, its three requesters and the SDRAM toggle port.
// slave = the scheduler; master = data_io, the two CPUs and the SDRAM controller.
interface rom_port_sched_if #(
    parameter int unsigned AW = 22
);
    logic          dl_active;
    logic          dl_wr;
    logic [AW:0]   dl_addr;
    logic [7:0]    dl_data;

    logic          cpu_req;
    logic [AW:0]   cpu_addr;
    logic [7:0]    cpu_dout;
    logic          cpu_rdy;

    logic          snd_req;
    logic [AW:0]   snd_addr;
    logic [7:0]    snd_dout;
    logic          snd_rdy;

    logic          port_req;
    logic          port_ack;
    logic [AW-1:0] port_a;
    logic [1:0]    port_ds;
    logic          port_we;
    logic [15:0]   port_d;
    logic [15:0]   port_q;

    logic          timeout;

    modport slave (
        input  dl_active, dl_wr, dl_addr, dl_data,
        input  cpu_req, cpu_addr, snd_req, snd_addr,
        input  port_ack, port_q,
        output cpu_dout, cpu_rdy, snd_dout, snd_rdy,
        output port_req, port_a, port_ds, port_we, port_d, timeout
    );

    modport master (
        output dl_active, dl_wr, dl_addr, dl_data,
        output cpu_req, cpu_addr, snd_req, snd_addr,
        output port_ack, port_q,
        input  cpu_dout, cpu_rdy, snd_dout, snd_rdy,
        input  port_req, port_a, port_ds, port_we, port_d, timeout
    );
endinterface

// File: rtl/rom_port_sched.sv
// Shares one SDRAM toggle-handshake port between the ROM download writes and two CPU readers.
// Optional per-reader one-word read cache: define ROM_CACHE_EN.
module rom_port_sched #(
    parameter int unsigned AW  = 22,
    parameter int unsigned TMO = 255
) (
    input  logic clk_sys,
    input  logic reset,
    rom_port_sched_if.slave bus
);
    localparam int unsigned BAW = AW + 1;
    localparam int unsigned FD  = 4;
    localparam int unsigned PW  = $clog2(FD);
    localparam int unsigned CW  = PW + 1;
    localparam logic [7:0]  TMO_C = 8'(TMO);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;
    typedef enum logic [1:0] {OWN_WR, OWN_CPU, OWN_SND} owner_t;

    state_t                  state_q, state_d;
    owner_t                  owner_q, owner_d;
    logic                    rr_q, rr_d;
    logic [7:0]              cnt_q, cnt_d;
    logic [FD-1:0][BAW-1:0]  fifo_addr_q, fifo_addr_d;
    logic [FD-1:0][7:0]      fifo_data_q, fifo_data_d;
    logic [PW-1:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]           count_q, count_d;

    logic                    port_req_q, port_req_d;
    logic [AW-1:0]           port_a_q, port_a_d;
    logic [1:0]              port_ds_q, port_ds_d;
    logic                    port_we_q, port_we_d;
    logic [15:0]             port_d_q, port_d_d;
    logic [7:0]              cpu_dout_q, cpu_dout_d, snd_dout_q, snd_dout_d;
    logic                    cpu_rdy_q, cpu_rdy_d, snd_rdy_q, snd_rdy_d;
    logic                    timeout_q, timeout_d;

    logic                    cpu_ok_c, snd_ok_c, pick_cpu_c, pick_snd_c;
    logic [BAW-1:0]          rd_addr_c, head_addr_c;
    logic [7:0]              head_data_c, q_byte_c, hit_byte_c;
    logic                    cpu_hit_c, snd_hit_c, rd_hit_c;
    logic [7:0]              cpu_hit_byte_c, snd_hit_byte_c;
    logic                    fifo_full_c, push_ok_c, pop_c;

    // A reader still seeing its own rdy pulse is not re-granted for the same request.
    assign cpu_ok_c    = bus.cpu_req && !cpu_rdy_q && !bus.dl_active;
    assign snd_ok_c    = bus.snd_req && !snd_rdy_q && !bus.dl_active;
    assign pick_cpu_c  = cpu_ok_c && (!rr_q || !snd_ok_c);
    assign pick_snd_c  = snd_ok_c && !pick_cpu_c;
    assign rd_addr_c   = pick_cpu_c ? bus.cpu_addr : bus.snd_addr;
    assign rd_hit_c    = pick_cpu_c ? cpu_hit_c : snd_hit_c;
    assign hit_byte_c  = pick_cpu_c ? cpu_hit_byte_c : snd_hit_byte_c;
    assign head_addr_c = fifo_addr_q[rd_ptr_q];
    assign head_data_c = fifo_data_q[rd_ptr_q];
    assign q_byte_c    = port_ds_q[1] ? bus.port_q[15:8] : bus.port_q[7:0];
    assign fifo_full_c = (count_q == CW'(FD));
    assign push_ok_c   = bus.dl_wr && !fifo_full_c;

`ifdef ROM_CACHE_EN
    logic [1:0]          cvld_q, cvld_d;
    logic [1:0][AW-1:0]  ctag_q, ctag_d;
    logic [1:0][15:0]    cword_q, cword_d;

    // Index 0 caches the main CPU, index 1 the sound CPU; any download activity invalidates.
    always_comb begin
        cvld_d  = cvld_q;
        ctag_d  = ctag_q;
        cword_d = cword_q;
        if (state_q == S_DONE && owner_q == OWN_CPU) begin
            cvld_d[0]  = 1'b1;
            ctag_d[0]  = port_a_q;
            cword_d[0] = bus.port_q;
        end
        if (state_q == S_DONE && owner_q == OWN_SND) begin
            cvld_d[1]  = 1'b1;
            ctag_d[1]  = port_a_q;
            cword_d[1] = bus.port_q;
        end
        if (bus.dl_wr || bus.dl_active) cvld_d = '0;
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            cvld_q  <= '0;
            ctag_q  <= '0;
            cword_q <= '0;
        end else begin
            cvld_q  <= cvld_d;
            ctag_q  <= ctag_d;
            cword_q <= cword_d;
        end
    end

    assign cpu_hit_c      = cvld_q[0] && (ctag_q[0] == bus.cpu_addr[BAW-1:1]);
    assign snd_hit_c      = cvld_q[1] && (ctag_q[1] == bus.snd_addr[BAW-1:1]);
    assign cpu_hit_byte_c = bus.cpu_addr[0] ? cword_q[0][15:8] : cword_q[0][7:0];
    assign snd_hit_byte_c = bus.snd_addr[0] ? cword_q[1][15:8] : cword_q[1][7:0];
`else
    assign cpu_hit_c      = 1'b0;
    assign snd_hit_c      = 1'b0;
    assign cpu_hit_byte_c = 8'h00;
    assign snd_hit_byte_c = 8'h00;
`endif

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        rr_d        = rr_q;
        cnt_d       = cnt_q;
        fifo_addr_d = fifo_addr_q;
        fifo_data_d = fifo_data_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        port_req_d  = port_req_q;
        port_a_d    = port_a_q;
        port_ds_d   = port_ds_q;
        port_we_d   = port_we_q;
        port_d_d    = port_d_q;
        cpu_dout_d  = cpu_dout_q;
        snd_dout_d  = snd_dout_q;
        cpu_rdy_d   = 1'b0;
        snd_rdy_d   = 1'b0;
        timeout_d   = timeout_q;
        pop_c       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (count_q != '0) begin
                    owner_d    = OWN_WR;
                    port_a_d   = head_addr_c[BAW-1:1];
                    port_ds_d  = {head_addr_c[0], ~head_addr_c[0]};
                    port_we_d  = 1'b1;
                    port_d_d   = {head_data_c, head_data_c};
                    port_req_d = ~port_req_q;
                    cnt_d      = 8'd0;
                    state_d    = S_WAIT;
                end else if (pick_cpu_c || pick_snd_c) begin
                    // Pointer always names the reader that was not just served.
                    rr_d = pick_cpu_c;
                    if (rd_hit_c) begin
                        if (pick_cpu_c) begin
                            cpu_dout_d = hit_byte_c;
                            cpu_rdy_d  = 1'b1;
                        end else begin
                            snd_dout_d = hit_byte_c;
                            snd_rdy_d  = 1'b1;
                        end
                    end else begin
                        owner_d    = pick_cpu_c ? OWN_CPU : OWN_SND;
                        port_a_d   = rd_addr_c[BAW-1:1];
                        port_ds_d  = {rd_addr_c[0], ~rd_addr_c[0]};
                        port_we_d  = 1'b0;
                        port_d_d   = 16'h0000;
                        port_req_d = ~port_req_q;
                        cnt_d      = 8'd0;
                        state_d    = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (bus.port_ack == port_req_q) begin
                    state_d = S_DONE;
                end else begin
                    if (cnt_q != TMO_C) cnt_d = cnt_q + 8'd1;
                    if (cnt_q == TMO_C - 8'd1) timeout_d = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                if (owner_q == OWN_WR) begin
                    pop_c = 1'b1;
                end else if (owner_q == OWN_CPU) begin
                    cpu_dout_d = q_byte_c;
                    cpu_rdy_d  = 1'b1;
                end else begin
                    snd_dout_d = q_byte_c;
                    snd_rdy_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Write FIFO: an overflowing push is dropped and flagged.
        if (bus.dl_wr && fifo_full_c) timeout_d = 1'b1;
        if (push_ok_c) begin
            fifo_addr_d[wr_ptr_q] = bus.dl_addr;
            fifo_data_d[wr_ptr_q] = bus.dl_data;
            wr_ptr_d              = wr_ptr_q + PW'(1);
        end
        if (pop_c) rd_ptr_d = rd_ptr_q + PW'(1);
        count_d = count_q + CW'(push_ok_c) - CW'(pop_c);
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            owner_q     <= OWN_WR;
            rr_q        <= 1'b0;
            cnt_q       <= 8'd0;
            fifo_addr_q <= '0;
            fifo_data_q <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            port_req_q  <= 1'b0;
            port_a_q    <= '0;
            port_ds_q   <= 2'b00;
            port_we_q   <= 1'b0;
            port_d_q    <= 16'h0000;
            cpu_dout_q  <= 8'h00;
            snd_dout_q  <= 8'h00;
            cpu_rdy_q   <= 1'b0;
            snd_rdy_q   <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            rr_q        <= rr_d;
            cnt_q       <= cnt_d;
            fifo_addr_q <= fifo_addr_d;
            fifo_data_q <= fifo_data_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            port_req_q  <= port_req_d;
            port_a_q    <= port_a_d;
            port_ds_q   <= port_ds_d;
            port_we_q   <= port_we_d;
            port_d_q    <= port_d_d;
            cpu_dout_q  <= cpu_dout_d;
            snd_dout_q  <= snd_dout_d;
            cpu_rdy_q   <= cpu_rdy_d;
            snd_rdy_q   <= snd_rdy_d;
            timeout_q   <= timeout_d;
        end
    end

    assign bus.port_req = port_req_q;
    assign bus.port_a   = port_a_q;
    assign bus.port_ds  = port_ds_q;
    assign bus.port_we  = port_we_q;
    assign bus.port_d   = port_d_q;
    assign bus.cpu_dout = cpu_dout_q;
    assign bus.cpu_rdy  = cpu_rdy_q;
    assign bus.snd_dout = snd_dout_q;
    assign bus.snd_rdy  = snd_rdy_q;
    assign bus.timeout  = timeout_q;
endmodule

// File: doc/rom_port_sched.md
Name: rom_port_sched

Overview:
- Schedules the single SDRAM port shared by three requesters:
  - the ROM download stream (data_io writes);
  - main-CPU ROM reads;
  - sound-CPU ROM reads.
- Sits between data_io/scramble_top and the sdram toggle-handshake port (req/ack toggles).
- Converts byte-wide requests into 16-bit word accesses with byte selects.
- Returns the selected byte to each reader with a ready pulse.

Parameters:
- AW, 22: SDRAM word-address width (byte address width is AW+1).
- TMO, 255: cycles to wait for the ack toggle before raising timeout (8-bit counter; TMO ≤ 255).

Ports:
- clk_sys  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- dl_active  in  1  download in progress; blocks and flushes reads.
- dl_wr  in  1  one-cycle write strobe.
- dl_addr  in  AW+1  byte address of the write.
- dl_data  in  8  byte to write.
- cpu_req  in  1  main-CPU read request (level, held until cpu_rdy).
- cpu_addr  in  AW+1  main-CPU byte address.
- cpu_dout  out  8  main-CPU read byte.
- cpu_rdy  out  1  one-cycle pulse; cpu_dout is valid in this cycle and is held afterwards.
- snd_req  in  1  sound-CPU read request (level).
- snd_addr  in  AW+1  sound-CPU byte address.
- snd_dout  out  8  sound-CPU read byte.
- snd_rdy  out  1  one-cycle pulse.
- port_req  out  1  SDRAM request toggle.
- port_ack  in  1  SDRAM acknowledge toggle.
- port_a  out  AW  word address.
- port_ds  out  2  byte selects: {hi, lo}.
- port_we  out  1  1 = write.
- port_d  out  16  write data; the byte is duplicated in both halves.
- port_q  in  16  read data.
- timeout  out  1  sticky flag; set when an ack is late.

Behaviour:
- Reset values:
  - port_req=0, port_we=0, port_ds=2'b00, port_a=0, port_d=0.
  - cpu_rdy=0, snd_rdy=0, cpu_dout=0, snd_dout=0, timeout=0.
  - State IDLE; write FIFO empty; round-robin pointer = main CPU.
- Write FIFO:
  - 4 entries; each holds {addr, data}.
  - dl_wr pushes an entry.
  - On push while full, the new entry is dropped and timeout is set.
- Request selection:
  - Any FIFO entry always wins.
  - Otherwise, when dl_active=0, arbitration is round-robin between cpu_req and snd_req.
  - The pointer moves to the other reader after each served read.
  - If the same reader is served again because the other is idle, the pointer is unchanged.
- Reads during download:
  - While dl_active=1, reads are not granted and the rdy outputs stay low.
- States:
  - IDLE: if a request is selected, latch addr/we/ds/d, toggle port_req, clear the timeout counter, go to WAIT. Otherwise stay in IDLE.
  - WAIT: when port_ack==port_req, go to DONE. Otherwise increment the counter; at TMO set timeout and stay in WAIT (the request is never reissued).
  - DONE:
    - Write: pop the FIFO.
    - Read: capture the byte port_q[15:8] if addr[0]=1, else port_q[7:0], into that reader's dout.
    - Pulse that reader's rdy for exactly 1 cycle.
    - Return to IDLE.
- Address and data mapping:
  - port_a = addr[AW:1].
  - port_ds = {addr[0], ~addr[0]}.
  - port_d = {data, data}.
- Latency:
  - Minimum read latency is IDLE→WAIT→DONE plus the SDRAM time: rdy asserts 2 cycles after the ack-match cycle.
- Reader contract and unsafe cases:
  - A reader must hold req and addr stable until rdy.
  - Dropping req before rdy is tolerated: the result is still written to dout, rdy still pulses, and it is ignored.
  - dl_active rising while a read is in WAIT: the read completes normally; subsequent reads are blocked.
- Reset mid-transaction:
  - All state returns to reset values immediately.
  - port_req returns to 0. The SDRAM side is reset by the same reset, so the toggle parity realigns.

Optional Feature:
- ROM_CACHE_EN:
  - When defined, each reader keeps one 16-bit word plus a valid bit, tagged with addr[AW:1].
  - cpu_req or snd_req whose word tag matches a valid entry is served without an SDRAM access: rdy pulses the cycle after req is seen, with the byte selected by addr[0].
  - A miss fills the entry in DONE.
  - Every FIFO push and dl_active=1 invalidate both entries.
- Without the macro, every read goes through the SDRAM port.

Test Plan:
- Download path: dl_active=1; write 0x12 at byte 0x0000 and 0x34 at 0x0001 on consecutive cycles, with the model acking after 6 cycles. Expect:
  - two write accesses: port_a=0, port_ds=01, port_d=0x1212, then port_ds=10, port_d=0x3434;
  - FIFO empty afterwards; no rdy pulses.
- Single read: cpu_req with cpu_addr=0x0001, model returns 0x3412. Expect cpu_dout=0x34 with exactly one cpu_rdy pulse; snd_rdy stays 0.
- Round-robin: cpu_req and snd_req asserted together and held, re-raised after each rdy. Expect grants alternating cpu, snd, cpu, snd over 4 reads.
- Timeout: the model never acks. Expect timeout=1 at cycle TMO after the toggle; state remains WAIT. Asserting reset returns port_req=0 and timeout=0.
- Write priority and overflow:
  - A write pushed while a cpu read is pending: the write is issued first, the read second.
  - 5 writes pushed with acks stalled: the fifth entry is dropped and timeout=1.
- ROM_CACHE_EN: read 0x0100, then read 0x0101. Expect the second cpu_rdy one cycle after req, with no port_req toggle. After a dl_wr, the same read misses and toggles port_req.
